// File: rtl/core_pipe_pkg.sv
// Shared definitions for core_pipe: opcodes, instruction field positions, flag indices
// and the execute-stage ALU function.
package core_pipe_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;

  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned RD_LSB  = 24;
  localparam int unsigned RS0_LSB = 20;
  localparam int unsigned RS1_LSB = 16;
  localparam int unsigned IMM_LSB = 0;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef struct packed {
    logic [15:0] result;
    logic [3:0]  flags;
  } alu_out_t;

  // Operates at the widest supported size; width masks everything down to the data width.
  function automatic alu_out_t alu_compute(input logic [3:0]  op,
                                           input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic [15:0] imm,
                                           input int unsigned width);
    alu_out_t    out;
    logic [16:0] mask, msb, ea, eb, r;
    logic        c, v, sa, sb, sr;
    mask = (17'd1 << width) - 17'd1;
    msb  = 17'd1 << (width - 1);
    ea   = {1'b0, a} & mask;
    eb   = {1'b0, b} & mask;
    sa   = |(ea & msb);
    sb   = |(eb & msb);
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      OP_ADD: begin
        r = ea + eb;
        c = |(r & (17'd1 << width));
        r = r & mask;
      end
      OP_SUB: begin
        r = (ea - eb) & mask;
        c = ea < eb;
      end
      OP_AND: r = ea & eb;
      OP_OR:  r = ea | eb;
      OP_XOR: r = ea ^ eb;
      OP_SHL: begin
        r = (ea << 1) & mask;
        c = sa;
      end
      OP_SHR: begin
        r = ea >> 1;
        c = ea[0];
      end
      OP_LDI: r = {1'b0, imm} & mask;
      OP_MOV: r = ea;
      default: r = '0;
    endcase
    sr = |(r & msb);
    if (op == OP_ADD) v = (sa == sb) && (sr != sa);
    else if (op == OP_SUB) v = (sa != sb) && (sr != sa);
    out.result        = 16'(r);
    out.flags[FLAG_C] = c;
    out.flags[FLAG_Z] = (r == '0);
    out.flags[FLAG_N] = sr;
    out.flags[FLAG_V] = v;
    return out;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push is accepted while full if a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr, r_rd;
  logic             w_do_pop, w_do_push;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_data    = r_mem[r_rd[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr[AW-1:0]] <= i_data;
        r_wr                <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/core_pipe.sv
// Two-stage (decode/read, execute) pipelined core with full forwarding from the execute
// stage and a result FIFO that absorbs consumer backpressure.
module core_pipe
  import core_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned REG_COUNT  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [31:0]           i_instr,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [3:0]            o_flags,
  output logic [3:0]            o_rd,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_illegal,
  output logic                  o_idle
);

  localparam int unsigned RW = $clog2(REG_COUNT);
  localparam int unsigned FW = DATA_WIDTH + 8;

  logic                  r_a_valid;
  logic [31:0]           r_a_instr;
  logic                  r_b_valid;
  logic [DATA_WIDTH-1:0] r_b_result;
  logic [3:0]            r_b_flags;
  logic [RW-1:0]         r_b_rd;
  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic                  r_illegal;

  logic [3:0]            w_op;
  logic [RW-1:0]         w_rd, w_rs0, w_rs1;
  logic [15:0]           w_imm;
  logic [DATA_WIDTH-1:0] w_opa, w_opb;
  alu_out_t              w_alu;
  logic                  w_a_writes, w_a_adv, w_b_fire, w_accept;
  logic                  w_full, w_empty;
  logic [FW-1:0]         w_fifo_in, w_fifo_out;

  assign w_op  = r_a_instr[OP_LSB +: 4];
  assign w_rd  = r_a_instr[RD_LSB +: RW];
  assign w_rs0 = r_a_instr[RS0_LSB +: RW];
  assign w_rs1 = r_a_instr[RS1_LSB +: RW];
  assign w_imm = r_a_instr[IMM_LSB +: 16];

  // Stage B is always younger-written than the register file, so it wins on a match.
  assign w_opa = (r_b_valid && r_b_rd == w_rs0 && w_rs0 != '0) ? r_b_result : r_regs[w_rs0];
  assign w_opb = (r_b_valid && r_b_rd == w_rs1 && w_rs1 != '0) ? r_b_result : r_regs[w_rs1];
  assign w_alu = alu_compute(w_op, 16'(w_opa), 16'(w_opb), w_imm, DATA_WIDTH);

  assign w_a_writes = (w_op != OP_NOP) && (w_op <= OP_MOV);
  assign w_b_fire   = r_b_valid && (!w_full || i_ready);
  assign w_a_adv    = r_a_valid && (!r_b_valid || w_b_fire);
  assign o_ready    = !i_RST && (!r_a_valid || w_a_adv);
  assign w_accept   = i_valid && o_ready;

  assign w_fifo_in = {4'(r_b_rd), r_b_flags, r_b_result};
  assign o_rd      = w_fifo_out[FW-1 -: 4];
  assign o_flags   = w_fifo_out[DATA_WIDTH +: 4];
  assign o_data    = w_fifo_out[DATA_WIDTH-1:0];
  assign o_valid   = !w_empty;
  assign o_illegal = r_illegal;
  assign o_idle    = !r_a_valid && !r_b_valid && w_empty;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_CLK),
    .i_rst   (i_RST),
    .i_push  (w_b_fire),
    .i_data  (w_fifo_in),
    .i_pop   (i_ready),
    .o_data  (w_fifo_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_a_valid  <= 1'b0;
      r_a_instr  <= '0;
      r_b_valid  <= 1'b0;
      r_b_result <= '0;
      r_b_flags  <= '0;
      r_b_rd     <= '0;
      r_illegal  <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      if (w_accept) begin
        r_a_valid <= 1'b1;
        r_a_instr <= i_instr;
      end else if (w_a_adv) begin
        r_a_valid <= 1'b0;
      end
      if (w_accept && i_instr[OP_LSB +: 4] > OP_MOV) r_illegal <= 1'b1;
      // NOP and illegal opcodes leave B empty, so they never reach the FIFO.
      if (w_a_adv) begin
        r_b_valid  <= w_a_writes;
        r_b_result <= DATA_WIDTH'(w_alu.result);
        r_b_flags  <= w_alu.flags;
        r_b_rd     <= w_rd;
      end else if (w_b_fire) begin
        r_b_valid <= 1'b0;
      end
      if (w_b_fire && r_b_rd != '0) r_regs[r_b_rd] <= r_b_result;
    end
  end

endmodule

// File: tb/tb_core_pipe.sv
// Directed self-checking bench for core_pipe: latency, forwarding, flags, backpressure,
// r0 handling, illegal opcodes and mid-stream reset.
module tb_core_pipe;

  logic        i_CLK = 1'b0;
  logic        i_RST;
  logic [31:0] i_instr;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  o_data;
  logic [3:0]  o_flags;
  logic [3:0]  o_rd;
  logic        o_valid;
  logic        i_ready;
  logic        o_illegal;
  logic        o_idle;

  core_pipe #(
    .DATA_WIDTH (8),
    .REG_COUNT  (16),
    .FIFO_DEPTH (4)
  ) dut (
    .i_CLK     (i_CLK),
    .i_RST     (i_RST),
    .i_instr   (i_instr),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_flags   (o_flags),
    .o_rd      (o_rd),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_illegal (o_illegal),
    .o_idle    (o_idle)
  );

  always #5 i_CLK = ~i_CLK;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [7:0] q_data[$];
  logic [3:0] q_flags[$];
  logic [3:0] q_rd[$];
  int         q_cyc[$];

  // Popped results with the edge number at which they left the FIFO.
  always @(posedge i_CLK) begin
    cyc = cyc + 1;
    if (!i_RST && o_valid && i_ready) begin
      q_data.push_back(o_data);
      q_flags.push_back(o_flags);
      q_rd.push_back(o_rd);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs0, input logic [3:0] rs1,
                                     input logic [15:0] imm);
    return {op, rd, rs0, rs1, imm};
  endfunction

  task automatic clear_q();
    q_data.delete();
    q_flags.delete();
    q_rd.delete();
    q_cyc.delete();
  endtask

  // Called at a negedge; returns the edge number at which the instruction was accepted.
  task automatic issue(input logic [31:0] ins, output int acc);
    int t;
    t = 0;
    i_instr = ins;
    i_valid = 1'b1;
    #1;
    while (!o_ready && t < 50) begin
      @(negedge i_CLK);
      #1;
      t++;
    end
    n_checks++;
    if (!o_ready) begin
      n_errors++;
      $display("FAIL issue_timeout: o_ready=%0b required 1", o_ready);
    end
    acc = cyc + 1;
    @(negedge i_CLK);
    i_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int t = 0; t < 100 && q_data.size() < n; t++) @(negedge i_CLK);
    n_checks++;
    if (q_data.size() < n) begin
      n_errors++;
      $display("FAIL result_timeout: got %0d results required %0d", q_data.size(), n);
    end
  endtask

  task automatic test_reset();
    i_RST = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_instr = '0;
    repeat (2) @(negedge i_CLK);
    #1;
    n_checks++;
    if (o_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_ready_low: got %0b required 0", o_ready);
    end
    @(negedge i_CLK);
    i_RST = 1'b0;
    #1;
    n_checks++;
    if ({o_ready, o_valid, o_idle, o_illegal} !== 4'b1010) begin
      n_errors++;
      $display("FAIL reset_state: ready/valid/idle/illegal got %b required 1010",
               {o_ready, o_valid, o_idle, o_illegal});
    end
    n_checks++;
    if ({o_data, o_flags, o_rd} !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_outputs: data/flags/rd got %h required 0000", {o_data, o_flags, o_rd});
    end
  endtask

  task automatic test_mov_zero();
    int acc;
    clear_q();
    issue(mk(4'd9, 4'd1, 4'd5, 4'd0, 16'h0), acc);
    wait_results(1);
    n_checks++;
    if (q_data[0] !== 8'h00 || q_flags[0] !== 4'b0010 || q_rd[0] !== 4'd1) begin
      n_errors++;
      $display("FAIL mov_zero: data=%h flags=%b rd=%0d required 00 0010 1",
               q_data[0], q_flags[0], q_rd[0]);
    end
    n_checks++;
    if (q_cyc[0] !== acc + 3) begin
      n_errors++; $display("FAIL mov_latency: popped at %0d required %0d", q_cyc[0], acc + 3);
    end
  endtask

  task automatic test_back_to_back();
    int         a0, a1, a2;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h7F; exp_d[1] = 8'h01; exp_d[2] = 8'h80;
    clear_q();
    issue(mk(4'd8, 4'd1, 4'd0, 4'd0, 16'h007F), a0);
    issue(mk(4'd8, 4'd2, 4'd0, 4'd0, 16'h0001), a1);
    issue(mk(4'd1, 4'd3, 4'd1, 4'd2, 16'h0), a2);
    wait_results(3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (q_data[i] !== exp_d[i] || q_cyc[i] !== a0 + 3 + i) begin
        n_errors++;
        $display("FAIL b2b_%0d: data=%h at %0d required %h at %0d",
                 i, q_data[i], q_cyc[i], exp_d[i], a0 + 3 + i);
      end
    end
    n_checks++;
    if (q_flags[2] !== 4'b1100 || q_rd[2] !== 4'd3) begin
      n_errors++;
      $display("FAIL b2b_add_flags: flags=%b rd=%0d required 1100 3", q_flags[2], q_rd[2]);
    end
  endtask

  task automatic test_forward_sub();
    int         a0, a;
    logic [7:0] exp_d [4];
    logic [3:0] exp_f [4];
    exp_d[0] = 8'h05; exp_d[1] = 8'h00; exp_d[2] = 8'h03; exp_d[3] = 8'hFD;
    exp_f[0] = 4'b0000; exp_f[1] = 4'b0010; exp_f[2] = 4'b0000; exp_f[3] = 4'b0101;
    clear_q();
    issue(mk(4'd8, 4'd1, 4'd0, 4'd0, 16'h0005), a0);
    issue(mk(4'd2, 4'd2, 4'd1, 4'd1, 16'h0), a);
    issue(mk(4'd8, 4'd4, 4'd0, 4'd0, 16'h0003), a);
    issue(mk(4'd2, 4'd5, 4'd0, 4'd4, 16'h0), a);
    wait_results(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (q_data[i] !== exp_d[i] || q_flags[i] !== exp_f[i] || q_cyc[i] !== a0 + 3 + i) begin
        n_errors++;
        $display("FAIL fwd_sub_%0d: data=%h flags=%b at %0d required %h %b at %0d",
                 i, q_data[i], q_flags[i], q_cyc[i], exp_d[i], exp_f[i], a0 + 3 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    i_ready = 1'b0;
    // r6 += r4 (r4 = 3) seven times, forwarding through the stalled stages.
    for (int i = 0; i < 6; i++) begin
      i_instr = mk(4'd1, 4'd6, 4'd4, 4'd6, 16'h0);
      i_valid = 1'b1;
      #1;
      n_checks++;
      if (o_ready !== 1'b1) begin
        n_errors++; $display("FAIL bp_accept_%0d: o_ready=%0b required 1", i, o_ready);
      end
      @(negedge i_CLK);
    end
    #1;
    n_checks++;
    if (o_ready !== 1'b0) begin
      n_errors++; $display("FAIL bp_seventh_blocked: o_ready=%0b required 0", o_ready);
    end
    repeat (3) @(negedge i_CLK);
    #1;
    n_checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 8'h03 || o_rd !== 4'd6 ||
        q_data.size() != 0) begin
      n_errors++;
      $display("FAIL bp_hold: ready=%0b valid=%0b data=%h rd=%0d pops=%0d required 0 1 03 6 0",
               o_ready, o_valid, o_data, o_rd, q_data.size());
    end
    i_ready = 1'b1;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_errors++; $display("FAIL bp_release_ready: o_ready=%0b required 1", o_ready);
    end
    @(negedge i_CLK);
    i_valid = 1'b0;
    wait_results(7);
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (q_data[i] !== 8'(3 * (i + 1)) || q_flags[i] !== 4'b0000 || q_rd[i] !== 4'd6) begin
        n_errors++;
        $display("FAIL bp_drain_%0d: data=%h flags=%b rd=%0d required %h 0000 6",
                 i, q_data[i], q_flags[i], q_rd[i], 8'(3 * (i + 1)));
      end
    end
    n_checks++;
    if (o_idle !== 1'b1) begin
      n_errors++; $display("FAIL bp_idle: o_idle=%0b required 1", o_idle);
    end
  endtask

  task automatic test_r0();
    int a;
    clear_q();
    issue(mk(4'd8, 4'd0, 4'd0, 4'd0, 16'h0055), a);
    issue(mk(4'd9, 4'd1, 4'd0, 4'd0, 16'h0), a);
    wait_results(2);
    n_checks++;
    if (q_data[0] !== 8'h55 || q_rd[0] !== 4'd0) begin
      n_errors++;
      $display("FAIL r0_ldi: data=%h rd=%0d required 55 0", q_data[0], q_rd[0]);
    end
    n_checks++;
    if (q_data[1] !== 8'h00 || q_flags[1] !== 4'b0010 || q_rd[1] !== 4'd1) begin
      n_errors++;
      $display("FAIL r0_mov: data=%h flags=%b rd=%0d required 00 0010 1",
               q_data[1], q_flags[1], q_rd[1]);
    end
    issue(mk(4'd9, 4'd2, 4'd0, 4'd0, 16'h0), a);
    wait_results(3);
    n_checks++;
    if (q_data[2] !== 8'h00) begin
      n_errors++; $display("FAIL r0_unchanged: data=%h required 00", q_data[2]);
    end
  endtask

  task automatic test_illegal_reset();
    int a;
    clear_q();
    issue(mk(4'hF, 4'd7, 4'd1, 4'd1, 16'h1234), a);
    repeat (4) @(negedge i_CLK);
    n_checks++;
    if (q_data.size() != 0 || o_illegal !== 1'b1 || o_idle !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal: pops=%0d illegal=%0b idle=%0b required 0 1 1",
               q_data.size(), o_illegal, o_idle);
    end
    i_ready = 1'b0;
    issue(mk(4'd8, 4'd3, 4'd0, 4'd0, 16'h0011), a);
    issue(mk(4'd8, 4'd4, 4'd0, 4'd0, 16'h0022), a);
    issue(mk(4'd8, 4'd5, 4'd0, 4'd0, 16'h0033), a);
    repeat (4) @(negedge i_CLK);
    n_checks++;
    if (o_valid !== 1'b1 || o_illegal !== 1'b1 || o_idle !== 1'b0 || o_data !== 8'h11) begin
      n_errors++;
      $display("FAIL queued: valid=%0b illegal=%0b idle=%0b data=%h required 1 1 0 11",
               o_valid, o_illegal, o_idle, o_data);
    end
    i_RST = 1'b1;
    @(negedge i_CLK);
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_illegal !== 1'b0 || o_idle !== 1'b1 || o_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset: valid=%0b illegal=%0b idle=%0b ready=%0b required 0 0 1 0",
               o_valid, o_illegal, o_idle, o_ready);
    end
    @(negedge i_CLK);
    i_RST = 1'b0;
    i_ready = 1'b1;
    clear_q();
    issue(mk(4'd9, 4'd1, 4'd3, 4'd0, 16'h0), a);
    wait_results(1);
    n_checks++;
    if (q_data[0] !== 8'h00 || q_flags[0] !== 4'b0010 || q_rd[0] !== 4'd1) begin
      n_errors++;
      $display("FAIL post_reset_mov: data=%h flags=%b rd=%0d required 00 0010 1",
               q_data[0], q_flags[0], q_rd[0]);
    end
  endtask

  initial begin
    test_reset();
    test_mov_zero();
    test_back_to_back();
    test_forward_sub();
    test_backpressure();
    test_r0();
    test_illegal_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
